multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter NINSTR_BITS, 32, instruction width.
REQ-002 Parameter NBITS_TOP, 8, retired-instruction counter width.
REQ-003 clk_2  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  1 = free-run; 0 = single-step.
REQ-006 step  in  1  level input; each rising edge advances one state when run=0.
REQ-007 instruction  in  NINSTR_BITS  word fetched at current pc.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-010 ir_load, pc_write, reg_write, mem_write  out  1 each  one-cycle write strobes.
REQ-011 mem_to_reg, branch, alu_src  out  1 each  datapath mux/branch controls.
REQ-012 alu_ctrl  out  3  ADD=0, SUB=1, AND=2, OR=3, SLT=4.
REQ-013 instr_cnt  out  NBITS_TOP  retired-instruction count.

Function
REQ-014 adv = run | (step & ~step_q); step_q is step registered each cycle.
REQ-015 State, IR and instr_cnt SHALL change only in cycles with adv=1 (except reset).
REQ-016 Strobes ir_load, pc_write, reg_write and mem_write SHALL be asserted only when adv=1. When adv=0, all four are 0 and the state holds.
REQ-017 FETCH: ir_load=1; IR <= instruction; next state DECODE.
REQ-018 DECODE: legal opcode/funct3 goes to EXEC; anything else goes to HALT. Legal set:
  - R 0110011: f3 000/111/110/010.
  - I 0010011: f3 000/111/110/010.
  - LW 0000011: f3 010.
  - SW 0100011: f3 010.
  - BEQ 1100011: f3 000.
REQ-019 alu_ctrl decode (driven in EXEC; 0 elsewhere):
  - R/I f3 000 gives ADD, except R with IR[30]=1 gives SUB.
  - f3 111 gives AND; f3 110 gives OR; f3 010 gives SLT.
  - LW/SW give ADD; BEQ gives SUB.
REQ-020 alu_src=1 in EXEC for I, LW and SW; 0 otherwise.
REQ-021 EXEC next state: R/I go to WB; LW/SW go to MEM; BEQ goes to FETCH.
REQ-022 EXEC for BEQ: branch=1 and pc_write=1; the datapath selects target when zero=1, else pc+4.
REQ-023 MEM next state: LW goes to WB; SW goes to FETCH with mem_write=1 and pc_write=1.
REQ-024 WB: reg_write=1, pc_write=1, mem_to_reg=1 for LW only; next state FETCH.
REQ-025 instr_cnt SHALL increment by 1 on every advancing transition into FETCH from EXEC, MEM or WB. It wraps 2^NBITS_TOP-1 to 0.
REQ-026 HALT is absorbing: all strobes 0, instr_cnt frozen, exit only via reset.
REQ-027 mem_to_reg, branch and alu_src SHALL be 0 in every state not listed above.
REQ-028 Strobe outputs are combinational from state, IR and adv. state and instr_cnt are registered.

Reset
REQ-029 With reset=1 at an edge: state=FETCH(0), IR=0, instr_cnt=0, step_q=0.
REQ-030 In any cycle with reset=1, all strobe outputs SHALL be 0.
REQ-031 Reset asserted mid-instruction (any state, including HALT) SHALL abort it with no further strobes. FETCH begins on the first cycle after reset deasserts.
REQ-032 A step that is already high when reset deasserts SHALL NOT produce an advance until it falls and rises again.

Verification
REQ-033 run=1, instruction=0x003100B3 (add): state 0,1,2,4,0; alu_ctrl=0 in EXEC; reg_write=1 only in WB; instr_cnt=1 after 4 cycles.
REQ-034 run=1, 0x00012083 (lw): state 0,1,2,3,4,0; alu_src=1 in EXEC; mem_to_reg=1 and reg_write=1 in WB; mem_write never set.
REQ-035 run=1, 0x00112223 (sw): state 0,1,2,3,0; mem_write=1 for exactly the MEM cycle; reg_write never set.
REQ-036 run=1, 0x00208463 (beq), zero=1: EXEC asserts branch=1, alu_ctrl=1, pc_write=1; returns to FETCH after 3 cycles; instr_cnt +1.
REQ-037 run=0, step held high 5 cycles then low: exactly one advance (FETCH to DECODE); ir_load high for one cycle only; no strobes in the remaining cycles.
REQ-038 Illegal-instruction, reset and wrap check:
  - run=1, instruction=0xFFFFFFFF: state 0,1,5, then stays 5 for 20 cycles with all strobes 0.
  - Assert reset: state=0 and instr_cnt=0.
  - Separately, 256 add instructions wrap instr_cnt to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a five-phase multicycle RISC-V subset core (R/I ALU ops, LW, SW, BEQ).
// Advances on free-run or on each rising edge of step; write strobes fire only on advancing cycles.
module multicycle_ctrl #(
   parameter int unsigned NINSTR_BITS = 32,
   parameter int unsigned NBITS_TOP   = 8
) (
   input  logic                   clk_2,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   step,
   input  logic [NINSTR_BITS-1:0] instruction,
   input  logic                   zero,
   output logic [2:0]             state,
   output logic                   ir_load,
   output logic                   pc_write,
   output logic                   reg_write,
   output logic                   mem_write,
   output logic                   mem_to_reg,
   output logic                   branch,
   output logic                   alu_src,
   output logic [2:0]             alu_ctrl,
   output logic [NBITS_TOP-1:0]   instr_cnt
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpI   = 7'b0010011;
   localparam logic [6:0] OpLw  = 7'b0000011;
   localparam logic [6:0] OpSw  = 7'b0100011;
   localparam logic [6:0] OpBeq = 7'b1100011;

   localparam logic [2:0] AluAdd = 3'd0;
   localparam logic [2:0] AluSub = 3'd1;
   localparam logic [2:0] AluAnd = 3'd2;
   localparam logic [2:0] AluOr  = 3'd3;
   localparam logic [2:0] AluSlt = 3'd4;

   state_e                 state_q, state_d;
   logic [NINSTR_BITS-1:0] ir_q, ir_d;
   logic [NBITS_TOP-1:0]   cnt_q, cnt_d;
   logic                   step_q, step_d;
   logic                   step_blk_q, step_blk_d;

   logic       adv;
   logic       retire;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_r, is_i, is_lw, is_sw, is_beq;
   logic       f3_alu_ok;
   logic       legal;
   logic [2:0] alu_dec;

   // The datapath consumes zero directly; the remaining IR fields are for the datapath too.
   logic unused_bits;
   assign unused_bits = ^{zero, ir_q[NINSTR_BITS-1:31], ir_q[29:15], ir_q[11:7]};

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];

   always_comb begin
      is_r      = (opcode == OpR);
      is_i      = (opcode == OpI);
      is_lw     = (opcode == OpLw) && (funct3 == 3'b010);
      is_sw     = (opcode == OpSw) && (funct3 == 3'b010);
      is_beq    = (opcode == OpBeq) && (funct3 == 3'b000);
      f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                  (funct3 == 3'b110) || (funct3 == 3'b010);
      legal     = ((is_r || is_i) && f3_alu_ok) || is_lw || is_sw || is_beq;

      alu_dec = AluAdd;
      if (is_r || is_i) begin
         case (funct3)
            3'b000:  alu_dec = (is_r && ir_q[30]) ? AluSub : AluAdd;
            3'b111:  alu_dec = AluAnd;
            3'b110:  alu_dec = AluOr;
            3'b010:  alu_dec = AluSlt;
            default: alu_dec = AluAdd;
         endcase
      end else if (is_beq) begin
         alu_dec = AluSub;
      end
   end

   // A step already high at reset release stays blocked until it has been seen low.
   assign step_d     = reset ? 1'b0 : step;
   assign step_blk_d = reset ? step : (step_blk_q & step);
   assign adv        = run | (step & ~step_q & ~step_blk_q);

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      cnt_d      = cnt_q;
      retire     = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      alu_src    = 1'b0;
      alu_ctrl   = AluAdd;

      if (reset) begin
         state_d = StFetch;
         ir_d    = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StFetch: begin
               ir_load = adv;
               if (adv) begin
                  ir_d    = instruction;
                  state_d = StDecode;
               end
            end
            StDecode: begin
               if (adv) state_d = legal ? StExec : StHalt;
            end
            StExec: begin
               alu_ctrl = alu_dec;
               alu_src  = is_i | is_lw | is_sw;
               branch   = is_beq;
               pc_write = adv & is_beq;
               if (adv) begin
                  if (is_beq) begin
                     state_d = StFetch;
                     retire  = 1'b1;
                  end else if (is_lw || is_sw) begin
                     state_d = StMem;
                  end else begin
                     state_d = StWb;
                  end
               end
            end
            StMem: begin
               mem_write = adv & is_sw;
               pc_write  = adv & is_sw;
               if (adv) begin
                  if (is_sw) begin
                     state_d = StFetch;
                     retire  = 1'b1;
                  end else begin
                     state_d = StWb;
                  end
               end
            end
            StWb: begin
               reg_write  = adv;
               pc_write   = adv;
               mem_to_reg = is_lw;
               if (adv) begin
                  state_d = StFetch;
                  retire  = 1'b1;
               end
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
         endcase
         if (retire) cnt_d = cnt_q + NBITS_TOP'(1);
      end
   end

   always_ff @(posedge clk_2) begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      step_blk_q <= step_blk_d;
   end

   assign state     = state_q;
   assign instr_cnt = cnt_q;

endmodule
